// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port word RAM.
// Sub-word stores use a read-modify-write sequence.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,

    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_wen,
    input  logic [31:0] d_req_wdata,
    input  logic [1:0]  d_req_size,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,

    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, IRESP, DRESP, RMW_WR} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          d_is_load;
    logic [31:0]   rmw_addr;
    logic [31:0]   rmw_wdata;
    logic [1:0]    rmw_size;

    logic          grant_i;
    logic          grant_d;
    logic          idle;
    logic          i_acc;
    logic          d_acc;
    logic          d_sub;
    logic [31:0]   merged;

    // Instruction wins only when data is absent or has hit the starvation limit.
    assign grant_i = i_req_valid && (!d_req_valid || (starve_cnt == CW'(STARVE_LIMIT)));
    assign grant_d = d_req_valid && !grant_i;

    // Gating with rst_n keeps the handshakes low while reset is held.
    assign idle        = rst_n && (state == IDLE);
    assign i_req_ready = idle && grant_i;
    assign d_req_ready = idle && grant_d;
    assign i_acc       = i_req_valid && i_req_ready;
    assign d_acc       = d_req_valid && d_req_ready;
    assign d_sub       = d_req_wen && !d_req_size[1];

    assign i_rsp_valid = (state == IRESP);
    assign i_rsp_data  = (state == IRESP) ? mem_rdata : '0;
    assign d_rsp_valid = (state == DRESP);
    assign d_rsp_data  = (state == DRESP && d_is_load) ? mem_rdata : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        merged = mem_rdata;
        if (rmw_size == 2'd0)
            merged[{rmw_addr[1:0], 3'b000} +: 8] = rmw_wdata[7:0];
        else
            merged[{rmw_addr[1], 4'b0000} +: 16] = rmw_wdata[15:0];
    end

    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        if (i_acc) begin
            mem_addr = i_req_addr;
        end else if (d_acc) begin
            mem_addr  = d_req_addr;
            mem_wen   = d_req_wen && !d_sub;
            mem_wdata = d_req_wdata;
        end else if (state == RMW_WR) begin
            mem_addr  = rmw_addr;
            mem_wen   = 1'b1;
            mem_wdata = merged;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            d_is_load  <= 1'b0;
            rmw_addr   <= '0;
            rmw_wdata  <= '0;
            rmw_size   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_acc) begin
                        state      <= IRESP;
                        starve_cnt <= '0;
                    end else if (d_acc) begin
                        if (!i_req_valid)
                            starve_cnt <= '0;
                        else if (starve_cnt != CW'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + 1'b1;
                        d_is_load <= !d_req_wen;
                        if (d_sub) begin
                            state     <= RMW_WR;
                            rmw_addr  <= d_req_addr;
                            rmw_wdata <= d_req_wdata;
                            rmw_size  <= d_req_size;
                        end else begin
                            state <= DRESP;
                        end
                    end
                end
                IRESP:   state <= IDLE;
                DRESP:   state <= IDLE;
                RMW_WR:  state <= DRESP;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, vector table, scoreboard of
// expected responses, starvation ordering and reset during read-modify-write.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_wen;
    logic [31:0] d_req_wdata;
    logic [1:0]  d_req_size;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wen(d_req_wen),
        .d_req_wdata(d_req_wdata), .d_req_size(d_req_size), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read.
    logic [31:0] ram [0:63];
    always_ff @(posedge clk) begin
        if (mem_wen && mem_addr[31:8] == 24'd0)
            ram[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        is_i;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (rst_n && (i_rsp_valid || d_rsp_valid)) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_kind", {31'd0, i_rsp_valid}, {31'd0, e.is_i});
                check("rsp_data", e.is_i ? i_rsp_data : d_rsp_data, e.data);
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    typedef struct {
        logic        is_i;
        logic        wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic idle_inputs();
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        d_req_valid = 1'b0;
        d_req_addr  = '0;
        d_req_wen   = 1'b0;
        d_req_wdata = '0;
        d_req_size  = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int waited;
        logic rdy;
        waited = 0;
        @(negedge clk);
        if (v.is_i) begin
            i_req_valid = 1'b1;
            i_req_addr  = v.addr;
        end else begin
            d_req_valid = 1'b1;
            d_req_addr  = v.addr;
            d_req_wen   = v.wen;
            d_req_wdata = v.wdata;
            d_req_size  = v.size;
        end
        #1;
        rdy = v.is_i ? i_req_ready : d_req_ready;
        while (!rdy && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
            rdy = v.is_i ? i_req_ready : d_req_ready;
        end
        if (!rdy) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back('{v.is_i, v.exp, cyc + v.lat});
            check("accept_wen", {31'd0, mem_wen}, {31'd0, v.wen && v.size[1]});
            check("accept_addr", mem_addr, v.addr);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        vec_t v;
        logic [9:0] grants;
        int g;
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 32'h04, 32'h0000_0013, 32'h0, 1};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 32'h08, 32'h1122_3344, 32'h0, 1};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h0C, 32'h5566_7788, 32'h0, 1};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'h04, 32'h0, 32'h0000_0013, 1};
        vecs[4]  = '{1'b0, 1'b0, 2'd2, 32'h08, 32'h0, 32'h1122_3344, 1};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h09, 32'hFFFF_FFAB, 32'h0, 2};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h08, 32'h0, 32'h1122_AB44, 1};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 32'h08, 32'h1122_3344, 32'h0, 1};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'h0A, 32'h0000_BEEF, 32'h0, 2};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'h08, 32'h0, 32'hBEEF_3344, 1};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 32'h0F, 32'h0000_005A, 32'h0, 2};
        vecs[13] = '{1'b0, 1'b1, 2'd1, 32'h0D, 32'h0000_1234, 32'h0, 2};
        vecs[14] = '{1'b1, 1'b0, 2'd2, 32'h0C, 32'h0, 32'h5A66_1234, 1};
        vecs[15] = '{1'b0, 1'b1, 2'd3, 32'h14, 32'hCAFE_F00D, 32'h0, 1};
        vecs[16] = '{1'b0, 1'b0, 2'd2, 32'h14, 32'h0, 32'hCAFE_F00D, 1};

        // Reset state with both requesters already asking.
        idle_inputs();
        rst_n = 1'b0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_i_ready", {31'd0, i_req_ready}, 32'd0);
        check("rst_d_ready", {31'd0, d_req_ready}, 32'd0);
        check("rst_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        check("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        check("rst_i_rsp_data", i_rsp_data, 32'd0);
        check("rst_d_rsp_data", d_rsp_data, 32'd0);
        idle_inputs();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            if (vecs[i].lat > 1) @(negedge clk);
        end

        // Both requesters held high: data wins four times, then instruction.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_addr  = 32'h04;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h10;
        d_req_wen   = 1'b0;
        d_req_size  = 2'd2;
        g = 0;
        grants = '0;
        for (int c = 0; c < 80 && g < 10; c++) begin
            #1;
            if (i_req_ready) begin
                grants[g] = 1'b1;
                sb.push_back('{1'b1, 32'h0000_0013, cyc + 1});
                g++;
            end else if (d_req_ready) begin
                grants[g] = 1'b0;
                sb.push_back('{1'b0, 32'hDEAD_BEEF, cyc + 1});
                g++;
            end
            @(negedge clk);
        end
        idle_inputs();
        check("starve_grant_count", g, 32'd10);
        for (int k = 0; k < 10; k++)
            check($sformatf("starve_grant_%0d", k), {31'd0, grants[k]}, {31'd0, (k % 5) == 4});
        repeat (3) @(negedge clk);

        // Reset asserted during the write half of a byte store.
        d_req_valid = 1'b1;
        d_req_addr  = 32'h15;
        d_req_wen   = 1'b1;
        d_req_wdata = 32'h0000_0099;
        d_req_size  = 2'd0;
        g = 0;
        #1;
        while (!d_req_ready && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("rmw_accept", {31'd0, d_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        check("rmw_wr_wen", {31'd0, mem_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_wen", {31'd0, mem_wen}, 32'd0);
        check("rmw_rst_rsp", {31'd0, d_rsp_valid}, 32'd0);
        @(negedge clk);
        check("rmw_rst_rsp_hold", {31'd0, d_rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, 1'b0, 2'd2, 32'h14, 32'h0, 32'hCAFE_F00D, 1};
        run_vec(v);

        for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports i_req_valid in 1, i_req_addr in 32, i_req_ready out 1: instruction-fetch request and its handshake.
REQ-005 The block SHALL have ports i_rsp_valid out 1, i_rsp_data out 32: fetched instruction word.
REQ-006 The block SHALL have ports d_req_valid in 1, d_req_addr in 32, d_req_wen in 1, d_req_wdata in 32, d_req_size in 2, d_req_ready out 1: data request; size 0=byte, 1=half, 2/3=word.
REQ-007 The block SHALL have ports d_rsp_valid out 1, d_rsp_data out 32: load data or store acknowledge.
REQ-008 The block SHALL have ports mem_addr out 32, mem_wen out 1, mem_wdata out 32, mem_rdata in 32: single-port word RAM, word index addr[31:2], registered read (data 1 cycle after address), write on clock edge.

Function
REQ-009 The block SHALL have FSM states IDLE, IRESP, DRESP, RMW_WR.
REQ-010 The block SHALL assert i_req_ready/d_req_ready only in IDLE, and only toward the granted requester; a transfer is accepted on valid && ready.
REQ-011 The block SHALL, in IDLE, grant data over instruction, except grant instruction when i_req_valid=1 and the starvation counter equals STARVE_LIMIT.
REQ-012 The block SHALL increment the starvation counter (saturating at STARVE_LIMIT) on each data grant with i_req_valid=1, and clear it on an instruction grant or when i_req_valid=0 at a data grant.
REQ-013 The block SHALL, on instruction accept at cycle T, drive mem_addr=i_req_addr, mem_wen=0, enter IRESP; at T+1 assert i_rsp_valid=1 for one cycle with i_rsp_data=mem_rdata, return to IDLE.
REQ-014 The block SHALL, on data load accept at T, drive mem_addr=d_req_addr, mem_wen=0, enter DRESP; at T+1 assert d_rsp_valid=1 for one cycle with d_rsp_data=mem_rdata (full word, no extension).
REQ-015 The block SHALL, on word store accept at T, drive mem_wen=1, mem_addr=d_req_addr, mem_wdata=d_req_wdata, enter DRESP; at T+1 pulse d_rsp_valid with d_rsp_data=0.
REQ-016 The block SHALL, on byte/half store accept at T, issue a read of d_req_addr (mem_wen=0), latch addr, wdata, size, and enter RMW_WR.
REQ-017 The block SHALL, in RMW_WR (T+1), drive mem_wen=1, latched mem_addr, mem_wdata=mem_rdata with selected lane replaced, enter DRESP; d_rsp_valid at T+2 with d_rsp_data=0.
REQ-018 The block SHALL use lane select: byte -> wdata[7:0] into byte addr[1:0]; half -> wdata[15:0] into bytes {addr[1],0} and {addr[1],1}; addr[0] ignored for half.
REQ-019 The block SHALL drive mem_wen=0 in IDLE without accept, IRESP and DRESP; mem_addr and mem_wdata are don't-care when mem_wen=0 and no read is issued.
REQ-020 The block SHALL give a new accept no earlier than the cycle after the response pulse, so each access occupies 2 cycles (sub-word store 3).
REQ-021 The block SHALL treat simultaneous i_req_valid and d_req_valid per REQ-011; the losing requester holds valid and is not accepted.

Reset
REQ-022 The block SHALL, while rst_n=0, immediately force state IDLE, starvation counter 0, i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid and mem_wen to 0, and i_rsp_data, d_rsp_data to 0.
REQ-023 The block SHALL abandon any in-flight access on reset with no response; an RMW interrupted before RMW_WR writes nothing.

Verification
REQ-024 Reset mid-RMW: assert rst_n=0 in RMW_WR cycle -> mem_wen=0 that cycle, no d_rsp_valid, memory word unchanged.
REQ-025 Fetch: mem[1]=0x00000013, i_req addr 0x4 alone -> i_req_ready at T, i_rsp_valid at T+1 with 0x00000013.
REQ-026 Byte store: mem[2]=0x11223344, store size 0 addr 0x9 wdata 0xAB -> mem[2]=0x1122AB44, d_rsp_valid at T+2.
REQ-027 Half store: mem[2]=0x11223344, size 1 addr 0xA wdata 0xBEEF -> mem[2]=0xBEEF3344.
REQ-028 Starvation: i_req_valid and d_req_valid held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I, repeating.
REQ-029 Word store then load same address 0x10 wdata 0xDEADBEEF -> load d_rsp_data=0xDEADBEEF.
